// File: rtl/tx_burst_sequencer.sv
// Frames a GMSK burst (prime, head tail, payload, end tail, guard) one symbol per modulator request.
// Define DIFF_ENCODE_EN to differentially encode the payload symbols.
module tx_burst_sequencer #(
  parameter int PRIME_SYMBOLS = 4,
  parameter int TAIL_SYMBOLS  = 3,
  parameter int GUARD_SYMBOLS = 8,
  parameter int LEN_BITS      = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                symbol_input_strobe,
  input  logic                symbol_iq_strobe,
  output logic                current_symbol,
  input  logic                start,
  input  logic [LEN_BITS-1:0] burst_len,
  output logic                ready,
  input  logic                payload_bit,
  input  logic                payload_valid,
  output logic                payload_ready,
  output logic                pa_enable,
  output logic                burst_done,
  output logic                underrun
);
  localparam int MAX_PARAM = (PRIME_SYMBOLS > TAIL_SYMBOLS) ?
      ((PRIME_SYMBOLS > GUARD_SYMBOLS) ? PRIME_SYMBOLS : GUARD_SYMBOLS) :
      ((TAIL_SYMBOLS > GUARD_SYMBOLS) ? TAIL_SYMBOLS : GUARD_SYMBOLS);
  localparam int PARAM_BITS = $clog2(MAX_PARAM) + 1;
  localparam int CNT_BITS   = (LEN_BITS > PARAM_BITS) ? LEN_BITS : PARAM_BITS;

  localparam logic [CNT_BITS-1:0] CNT_ZERO  = CNT_BITS'(0);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_PRIME = CNT_BITS'(PRIME_SYMBOLS);
  localparam logic [CNT_BITS-1:0] CNT_TAIL  = CNT_BITS'(TAIL_SYMBOLS);
  localparam logic [CNT_BITS-1:0] CNT_GUARD = CNT_BITS'(GUARD_SYMBOLS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRIME   = 3'd1,
    WAIT_IQ = 3'd2,
    HEAD    = 3'd3,
    PAYLOAD = 3'd4,
    TAIL    = 3'd5,
    GUARD   = 3'd6
  } state_t;

  state_t              state, state_n;
  logic [CNT_BITS-1:0] cnt, cnt_n;
  logic [LEN_BITS-1:0] len_q, len_n;
  logic                strobe_q;
  logic                sym_evt;
  logic                sym_val;
  logic                symbol_n;
  logic                pa_n;
  logic                done_n;
  logic                underrun_n;
  logic                payload_raw;
  logic                payload_sym;

  // A level strobe held for several cycles counts as a single symbol request.
  assign sym_evt       = symbol_input_strobe & ~strobe_q;
  assign ready         = (state == IDLE);
  assign payload_ready = (state == PAYLOAD) & sym_evt & payload_valid;
  assign payload_raw   = payload_valid ? payload_bit : 1'b1;

`ifdef DIFF_ENCODE_EN
  logic prev, prev_n;

  assign payload_sym = payload_raw ^ prev;

  // prev restarts at 1 on entry to HEAD and then follows each transmitted payload symbol.
  always_comb begin
    prev_n = prev;
    if ((state == WAIT_IQ) && symbol_iq_strobe) begin
      prev_n = 1'b1;
    end else if ((state == PAYLOAD) && sym_evt) begin
      prev_n = payload_sym;
    end else begin
      prev_n = prev;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b1;
    end else begin
      prev <= prev_n;
    end
  end
`else
  assign payload_sym = payload_raw;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, counter reloads and the symbol for the state consuming this event.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    len_n      = len_q;
    sym_val    = 1'b1;
    pa_n       = pa_enable;
    done_n     = 1'b0;
    underrun_n = underrun;
    case (state)
      IDLE: begin
        if (start) begin
          len_n      = burst_len;
          underrun_n = 1'b0;
          cnt_n      = CNT_PRIME;
          state_n    = PRIME;
        end else begin
          state_n = IDLE;
        end
      end
      PRIME: begin
        if (sym_evt) begin
          cnt_n   = cnt - CNT_ONE;
          state_n = (cnt == CNT_ONE) ? WAIT_IQ : PRIME;
        end else begin
          state_n = PRIME;
        end
      end
      WAIT_IQ: begin
        if (symbol_iq_strobe) begin
          pa_n    = 1'b1;
          cnt_n   = CNT_TAIL;
          state_n = HEAD;
        end else begin
          state_n = WAIT_IQ;
        end
      end
      HEAD: begin
        sym_val = 1'b0;
        if (sym_evt && (cnt == CNT_ONE)) begin
          if (len_q == {LEN_BITS{1'b0}}) begin
            cnt_n   = CNT_TAIL;
            state_n = TAIL;
          end else begin
            cnt_n   = CNT_BITS'(len_q);
            state_n = PAYLOAD;
          end
        end else if (sym_evt) begin
          cnt_n = cnt - CNT_ONE;
        end else begin
          state_n = HEAD;
        end
      end
      PAYLOAD: begin
        sym_val = payload_sym;
        if (sym_evt) begin
          underrun_n = underrun | ~payload_valid;
          if (cnt == CNT_ONE) begin
            cnt_n   = CNT_TAIL;
            state_n = TAIL;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end else begin
          state_n = PAYLOAD;
        end
      end
      TAIL: begin
        sym_val = 1'b0;
        if (sym_evt && (cnt == CNT_ONE)) begin
          cnt_n   = CNT_GUARD;
          state_n = GUARD;
        end else if (sym_evt) begin
          cnt_n = cnt - CNT_ONE;
        end else begin
          state_n = TAIL;
        end
      end
      GUARD: begin
        if (sym_evt && (cnt == CNT_ONE)) begin
          cnt_n   = CNT_ZERO;
          pa_n    = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (sym_evt) begin
          cnt_n = cnt - CNT_ONE;
        end else begin
          state_n = GUARD;
        end
      end
      default: begin
        cnt_n   = CNT_ZERO;
        pa_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
    if (sym_evt) begin
      symbol_n = sym_val;
    end else begin
      symbol_n = current_symbol;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= CNT_ZERO;
      len_q          <= {LEN_BITS{1'b0}};
      strobe_q       <= 1'b0;
      current_symbol <= 1'b1;
      pa_enable      <= 1'b0;
      burst_done     <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      cnt            <= cnt_n;
      len_q          <= len_n;
      strobe_q       <= symbol_input_strobe;
      current_symbol <= symbol_n;
      pa_enable      <= pa_n;
      burst_done     <= done_n;
      underrun       <= underrun_n;
    end
  end
endmodule

// File: doc/tx_burst_sequencer.md
Name: tx_burst_sequencer

Overview:
Control-plane sequencer for the GMSK modulator symbol interface. It accepts a burst request with a payload length and frames the burst: priming symbols, head tail bits, payload from a bit stream, end tail bits, and guard symbols. It generates PA enable and burst status. It sits between the burst scheduler or host and the modulator, driving current_symbol at each symbol request.

Parameters:
PRIME_SYMBOLS, 4, filler '1' symbols fed before the head tail while the modulator pipeline fills
TAIL_SYMBOLS, 3, '0' tail bits before and after the payload
GUARD_SYMBOLS, 8, '1' filler symbols after the end tail, with PA still on
LEN_BITS, 8, width of burst_len

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
symbol_input_strobe  in  1  modulator requests the next symbol (level; may stay high several cycles)
symbol_iq_strobe  in  1  first I/Q sample of a new symbol is on the modulator output
current_symbol  out  1  symbol value presented to the modulator
start  in  1  request a burst; accepted only when ready=1
burst_len  in  LEN_BITS  payload bit count, sampled on accept
ready  out  1  idle and able to accept start
payload_bit  in  1  payload stream data
payload_valid  in  1  payload stream valid
payload_ready  out  1  one-cycle pulse consuming payload_bit
pa_enable  out  1  RF PA enable
burst_done  out  1  one-cycle pulse at the end of a burst
underrun  out  1  sticky flag: payload unavailable when needed

Behaviour:
- Reset values: current_symbol=1, ready=1, payload_ready=0, pa_enable=0, burst_done=0, underrun=0, state=IDLE, all counters 0.
- Symbol edge: sym_evt is asserted when symbol_input_strobe=1 and its value registered on the previous cycle was 0. The block produces exactly one symbol per sym_evt. A strobe held high for N cycles still counts as one event.
- current_symbol is registered. On a sym_evt cycle, the value for the current state or count is loaded and takes effect on the next clock edge. It holds between events.
- States and transitions, with the counter reloaded on each entry:
  - IDLE: ready=1. If start=1, latch burst_len, clear underrun, go to PRIME with count=PRIME_SYMBOLS.
  - PRIME: symbol=1 per sym_evt; decrement. At 0, go to WAIT_IQ.
  - WAIT_IQ: symbol=1. On symbol_iq_strobe=1, set pa_enable=1 and go to HEAD.
  - HEAD: symbol=0 for TAIL_SYMBOLS events, then go to PAYLOAD. If the latched length is 0, go directly to TAIL.
  - PAYLOAD: per sym_evt:
    - If payload_valid=1: symbol=payload_bit and payload_ready pulses in the same cycle.
    - Else: symbol=1, underrun<=1, no pulse.
    - Either way, decrement the length. At 0, go to TAIL.
  - TAIL: symbol=0 for TAIL_SYMBOLS events, then go to GUARD.
  - GUARD: symbol=1 for GUARD_SYMBOLS events. On the last event: pa_enable<=0, burst_done pulses, go to IDLE.
- ready=1 only in IDLE. start is ignored elsewhere; there is no queueing.
- payload_ready never asserts outside PAYLOAD and asserts at most once per sym_evt.
- Counts per burst: PRIME_SYMBOLS + 2*TAIL_SYMBOLS + burst_len + GUARD_SYMBOLS events, plus the WAIT_IQ dwell. The maximum burst_len (2^LEN_BITS-1) must not wrap.
- A sym_evt coinciding with a state transition is consumed by the outgoing state; the incoming state starts on the next event.
- symbol_iq_strobe outside WAIT_IQ is ignored.
- Reset asserted mid-burst: immediate return to reset values, PA off, no burst_done pulse.
- Widths: counters are sized to max(LEN_BITS, clog2 of the largest parameter + 1).

Optional Feature:
DIFF_ENCODE_EN:
- Defined: payload symbols are differentially encoded, d = b XOR prev. prev resets to 1 at HEAD entry and updates to the transmitted payload symbol after each payload event. Underrun substitutes b=1 before encoding. Tail and guard symbols are not encoded.
- Undefined: payload bits pass through unchanged and no prev register exists.

Test Plan:
- Defaults, burst_len=2, payload 1,0 always valid, strobe every 10 cycles:
  - symbol sequence 1,1,1,1 | 0,0,0 | 1,0 | 0,0,0 | 1×8
  - pa_enable rises at the first symbol_iq_strobe after priming and falls with the single burst_done pulse.
- Strobe held high 5 cycles per event → one symbol per event; payload_ready pulses exactly twice for burst_len=2.
- burst_len=0 → HEAD goes directly to TAIL, 6 zeros back to back, payload_ready never asserted.
- payload_valid=0 for the second bit of 3 → that symbol=1, underrun=1 and stays 1 until the next accepted start.
- start pulsed while in PAYLOAD → ignored. reset_n low mid-PAYLOAD → pa_enable=0 and ready=1 asynchronously, no burst_done pulse.
- DIFF_ENCODE_EN, payload 1,1,0 → payload symbols 0,1,1.
